rf_writeback_arbiter: RTL

//  Write-side master for the 32x32 integer register file (2R/1W, x0 hard-wired zero).
//  - Merges two result sources onto the single RF write port (rf_we/rf_rd/rf_wd):
//    - single-cycle ALU/load results;
//    - variable-latency qubit measurement results from the quantum control unit.
//  - Keeps a pending-destination scoreboard so the decode stage stalls on registers awaiting measurement.

---
 rtl/rf_writeback_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Write-side master for the 32x32 integer register file. It merges single-cycle
//   ALU/load results and variable-latency measurement results onto the one RF write
//   port. It also keeps a pending-destination scoreboard that decode uses to stall.
// Ports
//   clk, rst_n                        clock and synchronous active-low reset
//   alu_valid/alu_rd/alu_wd/alu_ready ALU result handshake (core holds while !alu_ready)
//   meas_valid/meas_rd/meas_wd        measurement result offer
//   meas_ready                        buffer not full
//   issue_valid/issue_rd/issue_ready  measurement issue from decode
//   rf_we/rf_rd/rf_wd                 registered register-file write port
//   pending                           registers awaiting measurement writeback
module rf_writeback_arbiter #(
  parameter int MEAS_FIFO_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  output logic        alu_ready,
  input  logic        meas_valid,
  input  logic [4:0]  meas_rd,
  input  logic [31:0] meas_wd,
  output logic        meas_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic [31:0] pending
);

  localparam int PW = (MEAS_FIFO_DEPTH > 1) ? $clog2(MEAS_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(MEAS_FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd_r [0:MEAS_FIFO_DEPTH-1];
  logic [31:0]   fifo_wd_r [0:MEAS_FIFO_DEPTH-1];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] starve_r;
  logic [SW-1:0] starve_next_s;
  logic [OW-1:0] outstanding_r;
  logic [OW-1:0] outstanding_next_s;
  logic [31:0]   pending_r;
  logic [31:0]   pending_next_s;

  logic        empty_s;
  logic        full_s;
  logic        push_s;
  logic        issue_acc_s;
  logic        starve_hit_s;
  logic        alu_ready_s;
  logic        alu_grant_s;
  logic        head_grant_s;
  logic [4:0]  head_rd_s;
  logic [31:0] head_wd_s;

  assign empty_s      = (count_r == CW'(0));
  assign full_s       = (count_r == CW'(MEAS_FIFO_DEPTH));
  assign push_s       = meas_valid && !full_s;
  assign issue_acc_s  = issue_valid && issue_ready;
  assign starve_hit_s = !empty_s && (starve_r == SW'(STARVE_LIMIT));
  assign head_rd_s    = fifo_rd_r[rd_ptr_r];
  assign head_wd_s    = fifo_wd_r[rd_ptr_r];

  assign alu_ready   = alu_ready_s;
  assign meas_ready  = !full_s;
  assign issue_ready = (outstanding_r < OW'(MAX_OUTSTANDING));
  assign pending     = pending_r;

  // Grant selection: ALU first unless the buffered head has waited too long.
  always_comb begin
    alu_ready_s  = 1'b1;
    alu_grant_s  = 1'b0;
    head_grant_s = 1'b0;
    if (starve_hit_s) begin
      alu_ready_s  = 1'b0;
      head_grant_s = 1'b1;
    end else if (alu_valid) begin
      alu_grant_s = 1'b1;
    end else if (!empty_s) begin
      head_grant_s = 1'b1;
    end else begin
      head_grant_s = 1'b0;
    end
  end

  // Starvation counter next value; counts only while the head waits ungranted.
  always_comb begin
    starve_next_s = starve_r;
    if (head_grant_s) begin
      starve_next_s = SW'(0);
    end else if (!empty_s) begin
      starve_next_s = starve_r + SW'(1);
    end else begin
      starve_next_s = SW'(0);
    end
  end

  // Outstanding-count and pending-mask next values; a same-cycle issue overrides a clear.
  always_comb begin
    outstanding_next_s = outstanding_r;
    pending_next_s     = pending_r;
    if (issue_acc_s && !head_grant_s) begin
      outstanding_next_s = outstanding_r + OW'(1);
    end else if (!issue_acc_s && head_grant_s && (outstanding_r != OW'(0))) begin
      // Saturate: a result with nothing outstanding is a protocol error, flagged by the checker.
      outstanding_next_s = outstanding_r - OW'(1);
    end else begin
      outstanding_next_s = outstanding_r;
    end
    if (head_grant_s) begin
      pending_next_s[head_rd_s] = 1'b0;
    end else begin
      pending_next_s = pending_next_s;
    end
    if (issue_acc_s && (issue_rd != 5'd0)) begin
      pending_next_s[issue_rd] = 1'b1;
    end else begin
      pending_next_s = pending_next_s;
    end
    pending_next_s[0] = 1'b0;
  end

  // Measurement buffer: circular FIFO, push at tail, pop on head grant, no bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < MEAS_FIFO_DEPTH; i++) begin
        fifo_rd_r[i] <= 5'd0;
        fifo_wd_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        fifo_rd_r[wr_ptr_r] <= meas_rd;
        fifo_wd_r[wr_ptr_r] <= meas_wd;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end
      if (head_grant_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, head_grant_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Scoreboard and starvation state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_r      <= SW'(0);
      outstanding_r <= OW'(0);
      pending_r     <= 32'd0;
    end else begin
      starve_r      <= starve_next_s;
      outstanding_r <= outstanding_next_s;
      pending_r     <= pending_next_s;
    end
  end

  // Registered write port; x0 destinations consume the grant without writing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= 5'd0;
      rf_wd <= 32'd0;
    end else if (alu_grant_s) begin
      rf_we <= (alu_rd != 5'd0);
      rf_rd <= alu_rd;
      rf_wd <= alu_wd;
    end else if (head_grant_s) begin
      rf_we <= (head_rd_s != 5'd0);
      rf_rd <= head_rd_s;
      rf_wd <= head_wd_s;
    end else begin
      rf_we <= 1'b0;
    end
  end

  rf_writeback_arbiter_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .meas_xfer (push_s),
    .out_zero  (outstanding_r == OW'(0))
  );

endmodule

// rf_writeback_arbiter_chk
//   Protocol checker: a measurement result must not arrive with nothing outstanding.
// Ports
//   clk, rst_n  clock and reset of the arbiter
//   meas_xfer   measurement accepted this cycle
//   out_zero    no measurements outstanding
module rf_writeback_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic meas_xfer,
  input logic out_zero
);

  // Unsolicited measurement results indicate a broken quantum-unit handshake.
  a_no_unsolicited_meas : assert property (@(posedge clk) disable iff (!rst_n)
    !(meas_xfer && out_zero));

endmodule
